// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline slot with operand bypass and load-use stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    output logic [4:0]       r_reg1,
    output logic [4:0]       r_reg2,
    input  logic [WIDTH-1:0] r_data1,
    input  logic [WIDTH-1:0] r_data2,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             mem_fwd_valid,
    input  logic [4:0]       mem_fwd_rd,
    input  logic [WIDTH-1:0] mem_fwd_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_op1,
    output logic [WIDTH-1:0] out_op2,
    output logic [WIDTH-1:0] out_imm,
    output logic [WIDTH-1:0] out_pc,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             r_valid;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_pc;
    logic [4:0]       r_rd;
    logic             r_reg_write;
    logic             r_mem_read;
    logic [CNT_W-1:0] r_stall;

    logic             w_hazard;
    logic             w_ready;
    logic             w_accept;
    logic             w_fire;
    logic [WIDTH-1:0] w_op1;
    logic [WIDTH-1:0] w_op2;

    // MEM result is younger than writeback, so it takes priority; x0 is never bypassed.
    function automatic logic [WIDTH-1:0] f_sel(
        input logic [4:0]       idx,
        input logic [WIDTH-1:0] rf,
        input logic             mv,
        input logic [4:0]       mrd,
        input logic [WIDTH-1:0] mdata,
        input logic             wv,
        input logic [4:0]       wrd,
        input logic [WIDTH-1:0] wdata
    );
        if (idx == 5'd0)              return '0;
        else if (mv && (mrd == idx))  return mdata;
        else if (wv && (wrd == idx))  return wdata;
        else                          return rf;
    endfunction

    assign r_reg1 = in_rs1;
    assign r_reg2 = in_rs2;

    always_comb begin
        w_op1 = f_sel(in_rs1, r_data1, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                      wb_we, wb_rd, wb_data);
        w_op2 = f_sel(in_rs2, r_data2, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                      wb_we, wb_rd, wb_data);
    end

    // A load still in the slot has no data yet for a dependent consumer.
    assign w_hazard = r_valid && r_mem_read && (r_rd != 5'd0) &&
                      ((in_use_rs1 && (in_rs1 == r_rd)) ||
                       (in_use_rs2 && (in_rs2 == r_rd)));
    assign w_ready  = (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_accept = in_valid && w_ready;
    assign w_fire   = r_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_imm       <= in_imm;
            r_pc        <= in_pc;
            r_rd        <= in_rd;
            r_reg_write <= in_reg_write;
            r_mem_read  <= in_mem_read;
        end else if (w_fire) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (in_valid && w_hazard && !flush && (r_stall != {CNT_W{1'b1}})) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign in_ready      = w_ready;
    assign out_valid     = r_valid;
    assign out_op1       = r_op1;
    assign out_op2       = r_op2;
    assign out_imm       = r_imm;
    assign out_pc        = r_pc;
    assign out_rd        = r_rd;
    assign out_reg_write = r_reg_write;
    assign out_mem_read  = r_mem_read;
    assign stall_cycles  = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_rs1, in_rs2, in_rd;
    logic             in_use_rs1, in_use_rs2;
    logic [WIDTH-1:0] in_imm, in_pc;
    logic             in_reg_write, in_mem_read;
    logic [4:0]       r_reg1, r_reg2;
    logic [WIDTH-1:0] r_data1, r_data2;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             mem_fwd_valid;
    logic [4:0]       mem_fwd_rd;
    logic [WIDTH-1:0] mem_fwd_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_op1, out_op2, out_imm, out_pc;
    logic [4:0]       out_rd;
    logic             out_reg_write, out_mem_read;
    logic [15:0]      stall_cycles;

    // Narrow-counter instance sharing every input.
    logic             d2_in_ready;
    logic [4:0]       d2_reg1, d2_reg2;
    logic             d2_out_valid;
    logic [WIDTH-1:0] d2_op1, d2_op2, d2_imm, d2_pc;
    logic [4:0]       d2_rd;
    logic             d2_reg_write, d2_mem_read;
    logic [1:0]       d2_stall;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_imm(in_imm), .in_pc(in_pc), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .r_reg1(r_reg1), .r_reg2(r_reg2), .r_data1(r_data1), .r_data2(r_data2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_pc(out_pc),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .stall_cycles(stall_cycles)
    );

    id_ex_stage #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_imm(in_imm), .in_pc(in_pc), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .r_reg1(d2_reg1), .r_reg2(d2_reg2), .r_data1(r_data1), .r_data2(r_data2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .flush(flush), .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_op1(d2_op1), .out_op2(d2_op2), .out_imm(d2_imm), .out_pc(d2_pc),
        .out_rd(d2_rd), .out_reg_write(d2_reg_write), .out_mem_read(d2_mem_read),
        .stall_cycles(d2_stall)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: the instruction currently held in the slot.
    logic             m_valid;
    logic [WIDTH-1:0] m_op1, m_op2, m_imm, m_pc;
    logic [4:0]       m_rd;
    logic             m_rw, m_mr;
    int               m_stall;
    int               m_stall2;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value an instruction sees for register idx: newest producer wins, x0 reads zero.
    function automatic logic [WIDTH-1:0] operand(input logic [4:0] idx, input logic [WIDTH-1:0] rf);
        if (idx == 0) return 0;
        if (mem_fwd_valid && mem_fwd_rd == idx) return mem_fwd_data;
        if (wb_we && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    function automatic bit load_use();
        bit needs1, needs2;
        if (!m_valid || !m_mr || m_rd == 0) return 0;
        needs1 = in_use_rs1 && in_rs1 == m_rd;
        needs2 = in_use_rs2 && in_rs2 == m_rd;
        return needs1 || needs2;
    endfunction

    function automatic bit exp_ready();
        if (flush) return 0;
        if (load_use()) return 0;
        return !m_valid || out_ready;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_pc = 0;
        m_rd = 0; m_rw = 0; m_mr = 0; m_stall = 0; m_stall2 = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, WIDTH'(out_valid), WIDTH'(m_valid));
        check({tag, ".op1"},   out_op1, m_op1);
        check({tag, ".op2"},   out_op2, m_op2);
        check({tag, ".imm"},   out_imm, m_imm);
        check({tag, ".pc"},    out_pc,  m_pc);
        check({tag, ".rd"},    WIDTH'(out_rd), WIDTH'(m_rd));
        check({tag, ".rw"},    WIDTH'(out_reg_write), WIDTH'(m_rw));
        check({tag, ".mr"},    WIDTH'(out_mem_read), WIDTH'(m_mr));
        check({tag, ".stall"}, WIDTH'(stall_cycles), WIDTH'(m_stall));
        check({tag, ".stall2"}, WIDTH'(d2_stall), WIDTH'(m_stall2));
    endtask

    // Called just after a rising edge with inputs already driven; ends just after the next edge.
    task automatic cycle(input string tag);
        bit rdy, haz;
        #1;
        rdy = exp_ready();
        haz = load_use();
        check({tag, ".in_ready"}, WIDTH'(in_ready), WIDTH'(rdy));
        check({tag, ".reg1"}, WIDTH'(r_reg1), WIDTH'(in_rs1));
        check({tag, ".reg2"}, WIDTH'(r_reg2), WIDTH'(in_rs2));
        if (in_valid && haz && !flush) begin
            if (m_stall < 65535) m_stall++;
            if (m_stall2 < 3) m_stall2++;
        end
        if (flush) begin
            m_valid = 0;
        end else if (in_valid && rdy) begin
            m_valid = 1;
            m_op1 = operand(in_rs1, r_data1);
            m_op2 = operand(in_rs2, r_data2);
            m_imm = in_imm; m_pc = in_pc; m_rd = in_rd;
            m_rw = in_reg_write; m_mr = in_mem_read;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_use_rs1 = 0; in_use_rs2 = 0; in_imm = 0; in_pc = 0;
        in_reg_write = 0; in_mem_read = 0; r_data1 = 0; r_data2 = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
        mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic load);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_use_rs1 = 1; in_use_rs2 = 1; in_mem_read = load; in_reg_write = 1;
        in_imm = $urandom; in_pc = $urandom;
    endtask

    logic [WIDTH-1:0] held_op1, held_pc;
    int               stall_before;

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();
        #12 rst = 0;
        @(posedge clk); #1;

        // Reset state.
        check("reset.in_ready", WIDTH'(in_ready), 1);
        check_outputs("reset");
        cycle("idle");

        // Writeback bypass on rs2, register file on rs1.
        instr(5, 6, 9, 0);
        r_data1 = 32'h11; r_data2 = 32'h22;
        wb_we = 1; wb_rd = 6; wb_data = 32'hABCD;
        cycle("wb_fwd");
        check("wb_fwd.op1_const", out_op1, 32'h11);
        check("wb_fwd.op2_const", out_op2, 32'hABCD);

        // MEM bypass beats writeback on the same index.
        mem_fwd_valid = 1; mem_fwd_rd = 6; mem_fwd_data = 32'h77;
        wb_rd = 6; wb_data = 32'h99;
        cycle("mem_prio");
        check("mem_prio.op2_const", out_op2, 32'h77);

        // x0 is never bypassed.
        in_rs2 = 0; mem_fwd_rd = 0; wb_rd = 0;
        cycle("x0");
        check("x0.op2_const", out_op2, 0);

        // Load-use: one bubble, then the dependent instruction takes load data from MEM.
        idle_inputs();
        instr(1, 2, 7, 1);
        cycle("ld");
        stall_before = m_stall;
        instr(7, 3, 8, 0);
        #1;
        check("ldu.in_ready_low", WIDTH'(in_ready), 0);
        #0;
        cycle("ldu_bubble");
        check("ldu.bubble", WIDTH'(out_valid), 0);
        mem_fwd_valid = 1; mem_fwd_rd = 7; mem_fwd_data = 32'h1234;
        cycle("ldu_accept");
        check("ldu.op1_const", out_op1, 32'h1234);
        check("ldu.stall_const", WIDTH'(stall_cycles), WIDTH'(stall_before + 1));

        // Same pattern with rs1 unused: no stall.
        idle_inputs();
        instr(1, 2, 7, 1);
        cycle("ld2");
        instr(7, 3, 8, 0);
        in_use_rs1 = 0;
        cycle("nouse");
        check("nouse.valid_const", WIDTH'(out_valid), 1);

        // Back-pressure holds payload; flush then empties the slot.
        idle_inputs();
        instr(4, 5, 10, 0);
        r_data1 = 32'hCAFE;
        cycle("bp_load");
        held_op1 = out_op1; held_pc = out_pc;
        out_ready = 0;
        instr(11, 12, 13, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            check("bp.op1_stable", out_op1, held_op1);
            check("bp.pc_stable", out_pc, held_pc);
        end
        flush = 1;
        cycle("flush");
        check("flush.valid_const", WIDTH'(out_valid), 0);
        flush = 0; in_valid = 0; out_ready = 1;
        cycle("post_flush");

        // Five hazard cycles saturate the 2-bit counter.
        idle_inputs();
        instr(1, 1, 3, 1);
        cycle("sat_ld");
        out_ready = 0;
        instr(3, 0, 4, 0);
        for (int i = 0; i < 5; i++) cycle("sat");
        check("sat.d2_const", WIDTH'(d2_stall), 3);

        // Asynchronous reset mid-cycle with a valid slot.
        check("areset.pre_valid", WIDTH'(out_valid), 1);
        in_valid = 0;
        #2 rst = 1;
        #1;
        check("areset.valid", WIDTH'(out_valid), 0);
        check("areset.op1", out_op1, 0);
        model_reset();
        idle_inputs();
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        check_outputs("areset");

        // Randomized traffic with small register indices to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_rs1 = 5'($urandom_range(0, 7));
            in_rs2 = 5'($urandom_range(0, 7));
            in_rd  = 5'($urandom_range(0, 7));
            in_use_rs1 = $urandom_range(0, 1);
            in_use_rs2 = $urandom_range(0, 1);
            in_imm = $urandom; in_pc = $urandom;
            in_reg_write = $urandom_range(0, 1);
            in_mem_read = ($urandom_range(0, 2) == 0);
            r_data1 = $urandom; r_data2 = $urandom;
            wb_we = $urandom_range(0, 1);
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            mem_fwd_valid = $urandom_range(0, 1);
            mem_fwd_rd = 5'($urandom_range(0, 7));
            mem_fwd_data = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage and direct consumer of the register file's two asynchronous read ports.
- Drives the read addresses combinationally from the incoming decoded instruction.
- Bypasses same-cycle writeback and MEM-stage results, because the register file has no write-through.
- Detects load-use hazards and registers operands, immediate, PC and control into a valid/ready ID/EX slot feeding the ALU stage.

Parameters:
WIDTH, 32, datapath/register width
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_rs1, in_rs2, in_rd  in  5 each  register indices
in_use_rs1, in_use_rs2  in  1 each  instruction actually reads rs1/rs2
in_imm  in  WIDTH  sign-extended immediate
in_pc  in  WIDTH  instruction address
in_reg_write  in  1  instruction writes rd
in_mem_read  in  1  instruction is a load
r_reg1, r_reg2  out  5 each  register-file read addresses (= in_rs1, in_rs2, combinational)
r_data1, r_data2  in  WIDTH each  register-file read data (async)
wb_we  in  1  writeback this cycle (same signals as register-file write port)
wb_rd  in  5  writeback index
wb_data  in  WIDTH  writeback value
mem_fwd_valid  in  1  MEM stage holds a result for mem_fwd_rd
mem_fwd_rd  in  5  MEM-stage destination
mem_fwd_data  in  WIDTH  MEM-stage result (load data for loads)
flush  in  1  kill slot contents (branch redirect)
out_valid  out  1  slot holds valid instruction
out_ready  in  1  EX stage accepts
out_op1, out_op2, out_imm, out_pc  out  WIDTH each  registered operands/immediate/PC
out_rd  out  5  registered destination
out_reg_write, out_mem_read  out  1 each  registered control
stall_cycles  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Clock port clk; reset port rst, asynchronous, active-high; one clock domain.
- Reset:
  - out_valid=0; all out_* payload=0; stall_cycles=0.
  - in_ready depends only on reset state → 1 after reset (slot empty, no hazard).
- Operand select for rs1 (rs2 identical), priority order:
  - (1) index 0 → 0;
  - (2) mem_fwd_valid && mem_fwd_rd==rs1 → mem_fwd_data;
  - (3) wb_we && wb_rd==rs1 → wb_data;
  - (4) r_data1.
  - x0 is never forwarded.
- fire_out = out_valid && out_ready.
- hazard = out_valid && out_mem_read && out_rd!=0 && ((in_use_rs1 && in_rs1==out_rd) || (in_use_rs2 && in_rs2==out_rd)).
- in_ready = (!out_valid || out_ready) && !hazard && !flush. Combinational; no path from in_valid.
- accept = in_valid && in_ready.
- Slot update per edge, priority order:
  - flush → out_valid=0, payload unchanged;
  - accept → load selected operands, imm, pc, rd, control; out_valid=1;
  - fire_out → out_valid=0 (bubble);
  - else hold.
  - Payload is stable while out_valid && !out_ready.
- Load-use stall sequence, with a load in the slot and a dependent instruction at input:
  - Cycle N: in_ready=0. If out_ready, the load leaves and the slot becomes a bubble.
  - Cycle N+1: hazard clears and the dependent instruction is accepted; load data arrives through mem_fwd.
  - Total penalty: exactly 1 bubble when out_ready is held high.
- stall_cycles increments on every cycle with in_valid && hazard && !flush; saturates at all-ones and never wraps.
- Simultaneous events:
  - flush with accept → flush wins, instruction discarded (in_ready is 0 anyway).
  - wb and mem_fwd to same index → mem_fwd wins.
  - wb to x0 → ignored.
- Reset asserted mid-stall or mid-handshake clears the slot immediately, without waiting for a clock edge.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, stall_cycles=0, all outputs 0; assert rst asynchronously mid-cycle with out_valid=1 → out_valid=0 before the next edge.
- Accept rs1=5, rs2=6 with r_data1=0x11, r_data2=0x22, wb_we=1, wb_rd=6, wb_data=0xABCD → next cycle out_op1=0x11, out_op2=0xABCD.
- mem_fwd_valid=1, mem_fwd_rd=6, mem_fwd_data=0x77 plus wb_rd=6, wb_data=0x99 → out_op2=0x77; repeat with rs2=0 and both forwarding to 0 → out_op2=0.
- Load rd=7 in slot, next instruction rs1=7 with out_ready=1 → in_ready=0 for 1 cycle, one bubble (out_valid=0), then accepted with out_op1=mem_fwd_data; stall_cycles=1. With in_use_rs1=0 instead → no stall.
- out_ready=0 for 3 cycles with a valid slot → payload constant, in_ready=0; then flush=1 → out_valid=0 next cycle, nothing accepted.
- Force CNT_W=2 and 5 consecutive hazard cycles → stall_cycles reaches 3 and stays at 3.
